// File: rtl/scsi_byte_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scsi_byte_seq_pkg
//  Brief    : Shared types and constants for the SCSI-side byte sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package scsi_byte_seq_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_XFER = 3'd1,
      ST_WR   = 3'd2,
      ST_RD   = 3'd3,
      ST_FL   = 3'd4
   } seq_state_e;

   // Transfer direction as sampled on START
   localparam logic DIR_S2F = 1'b1;
   localparam logic DIR_F2S = 1'b0;

   // Byte-lane indices
   localparam logic [1:0] LANE_FIRST = 2'd0;
   localparam logic [1:0] LANE_LAST  = 2'd3;

   // Byte count reported with a full-word write
   localparam logic [2:0] WR_BYTES_WORD = 3'd4;

   // Bit offset of a byte lane inside the 32-bit word.
   // Big-endian puts lane 0 at bits 31:24, little-endian at bits 7:0.
   function automatic logic [4:0] lane_lsb(input logic [1:0] lane, input logic big_endian);
      lane_lsb = big_endian ? {~lane, 3'b000} : {lane, 3'b000};
   endfunction

endpackage
`default_nettype wire

// File: rtl/scsi_byte_pack.sv
`default_nettype none
// ============================================================================
//  Module   : scsi_byte_pack
//  Brief    : 32-bit packing register; writes one byte lane at a time,
//             lane placement chosen by BIG_ENDIAN, synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module scsi_byte_pack
   import scsi_byte_seq_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clr,
   input  logic        i_we,
   input  logic [1:0]  i_lane,
   input  logic [7:0]  i_din,
   output logic [31:0] o_data
);

   logic [31:0] data_q;
   logic [31:0] data_d;

   // Next word: clear wins over a lane write; otherwise drop the byte into its lane
   always_comb begin
      data_d = data_q;
      if (i_clr) begin
         data_d = '0;
      end else if (i_we) begin
         data_d[lane_lsb(i_lane, BIG_ENDIAN) +: 8] = i_din;
      end
   end

   // Packing register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign o_data = data_q;

endmodule
`default_nettype wire

// File: rtl/scsi_byte_seq.sv
`default_nettype none
// ============================================================================
//  Module   : scsi_byte_seq
//  Brief    : SCSI-side byte sequencer between the 32-bit FIFO and the 8-bit
//             SCSI datapath: lane counting, word packing, read pacing, flush.
//  Revision : 1.0 - initial release
// ============================================================================
module scsi_byte_seq
   import scsi_byte_seq_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        START,
   input  logic        DIR,
   input  logic        BYTE_STB,
   input  logic [7:0]  SCSI_BYTE,
   input  logic        FIFO_FULL,
   input  logic        FIFO_EMPTY,
   input  logic        FLUSH,
   output logic        BYTE_RDY,
   output logic        BO0,
   output logic        BO1,
   output logic [31:0] PACKED_DATA,
   output logic        FIFO_WR,
   output logic [2:0]  WR_BYTES,
   output logic        FIFO_RD,
   output logic        FLUSH_DONE
);

   seq_state_e state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       dir_q, dir_d;
   logic       flush_pend_q, flush_pend_d;   // FLUSH seen while a word op was in flight
   logic       rd_settle_q, rd_settle_d;     // give FIFO_EMPTY a cycle to follow a read

   logic       byte_rdy;
   logic       take;
   logic       fifo_wr;
   logic [2:0] wr_bytes;
   logic       fifo_rd;
   logic       flush_done;
   logic       pack_we;
   logic       pack_clr;

   // Next-state and output decode; START overrides everything at the end
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dir_d        = dir_q;
      flush_pend_d = flush_pend_q;
      rd_settle_d  = 1'b0;
      byte_rdy     = 1'b0;
      take         = 1'b0;
      fifo_wr      = 1'b0;
      wr_bytes     = 3'd0;
      fifo_rd      = 1'b0;
      flush_done   = 1'b0;
      pack_we      = 1'b0;

      case (state_q)
         ST_IDLE: begin
         end

         ST_XFER: begin
            if (dir_q == DIR_S2F) begin
               byte_rdy = ~FIFO_FULL;
            end else begin
               byte_rdy = ~FIFO_EMPTY & ~rd_settle_q;
            end
            take = BYTE_STB & byte_rdy;
            if (take) begin
               cnt_d   = cnt_q + 2'd1;
               pack_we = (dir_q == DIR_S2F);
            end
            // A completing byte takes precedence; a coincident FLUSH waits behind it
            if (take && (cnt_q == LANE_LAST)) begin
               state_d      = (dir_q == DIR_S2F) ? ST_WR : ST_RD;
               flush_pend_d = FLUSH;
            end else if (FLUSH) begin
               state_d = ST_FL;
               if (dir_q == DIR_F2S) begin
                  cnt_d = LANE_FIRST;
               end
            end
         end

         ST_WR: begin
            fifo_wr  = ~FIFO_FULL;
            wr_bytes = fifo_wr ? WR_BYTES_WORD : 3'd0;
            if (FLUSH) begin
               flush_pend_d = 1'b1;
            end
            if (!FIFO_FULL) begin
               state_d = (flush_pend_q | FLUSH) ? ST_FL : ST_XFER;
            end
         end

         ST_RD: begin
            fifo_rd     = 1'b1;
            rd_settle_d = 1'b1;
            state_d     = (flush_pend_q | FLUSH) ? ST_FL : ST_XFER;
         end

         ST_FL: begin
            // Partial S2F word goes out first; FLUSH_DONE follows once CNT is zero
            if ((dir_q == DIR_S2F) && (cnt_q != LANE_FIRST)) begin
               fifo_wr  = ~FIFO_FULL;
               wr_bytes = fifo_wr ? {1'b0, cnt_q} : 3'd0;
               if (!FIFO_FULL) begin
                  cnt_d = LANE_FIRST;
               end
            end else begin
               flush_done   = 1'b1;
               flush_pend_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (START) begin
         state_d      = ST_XFER;
         cnt_d        = LANE_FIRST;
         dir_d        = DIR;
         flush_pend_d = 1'b0;
         rd_settle_d  = 1'b0;
         fifo_wr      = 1'b0;
         wr_bytes     = 3'd0;
         fifo_rd      = 1'b0;
         flush_done   = 1'b0;
         pack_we      = 1'b0;
      end
   end

   // Sequencer state registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= ST_IDLE;
         cnt_q        <= LANE_FIRST;
         dir_q        <= DIR_F2S;
         flush_pend_q <= 1'b0;
         rd_settle_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dir_q        <= dir_d;
         flush_pend_q <= flush_pend_d;
         rd_settle_q  <= rd_settle_d;
      end
   end

   // The word leaving on FIFO_WR is cleared behind it; START discards any partial word
   assign pack_clr = fifo_wr | START;

   scsi_byte_pack #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_pack (
      .clk    (CLK),
      .rst_n  (nRST),
      .i_clr  (pack_clr),
      .i_we   (pack_we),
      .i_lane (cnt_q),
      .i_din  (SCSI_BYTE),
      .o_data (PACKED_DATA)
   );

   assign BYTE_RDY   = byte_rdy;
   assign BO0        = cnt_q[0];
   assign BO1        = cnt_q[1];
   assign FIFO_WR    = fifo_wr;
   assign WR_BYTES   = wr_bytes;
   assign FIFO_RD    = fifo_rd;
   assign FLUSH_DONE = flush_done;

endmodule
`default_nettype wire
